crossbar_cfg: RTL and testbench
===============================

# crossbar_cfg

Configuration front-end for the PMU event crossbar. It accepts single-word register-bus reads and writes and packs the per-counter select fields into 32-bit words held in a shadow copy. On an explicit commit it transfers the shadow copy atomically to the live `cfg_o` vector that drives the crossbar muxes. It also brackets each live update with a busy/settle window so the counter logic can ignore the crossbar's registered output while it refreshes.

## Interface
- `N_OUT`, 24: number of crossbar outputs (PMU counters); one select field each.
- `N_IN`, 32: number of crossbar inputs (SoC events); legal field values are 0..N_IN-1.
- `DATA_W`, 32: register-bus data width.
- Local values:
  - `B = $clog2(N_IN)`: field width.
  - `F = DATA_W / B`: fields per word.
  - `N_WORDS = ceil(N_OUT/F)`.
  - `ADDR_W = $clog2(N_WORDS+1)`.
  - `CTRL = N_WORDS`: control/status word index.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  access request.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  ADDR_W  word index.
- `wdata_i`  in  DATA_W  write data.
- `gnt_o`  out  1  request accepted this cycle (combinational).
- `rvalid_o`  out  1  response valid, one cycle after grant.
- `rdata_o`  out  DATA_W  read data; valid with `rvalid_o`, 0 otherwise.
- `err_o`  out  1  access error; valid with `rvalid_o`.
- `cfg_o`  out  B × N_OUT (unpacked [0:N_OUT-1])  live select fields to the crossbar.
- `busy_o`  out  1  commit in progress; live mapping unstable.
- `dirty_o`  out  1  shadow differs from live by at least one accepted write since the last commit or discard.

## Operation
- Field packing: counter `i = w*F + k` occupies `wdata[k*B +: B]` of word `w`.
  - Bits above `F*B` are ignored on write and read as 0.
  - Fields with index ≥ N_OUT are ignored on write and read as 0.
- Reset value of every shadow and live field: `i mod N_IN` (identity mapping).
- Shadow write, address < N_WORDS:
  - If any in-range field value is ≥ N_IN, the whole word is rejected: `err_o`=1 and the shadow is unchanged.
  - Otherwise all fields of the word are updated and `dirty_o` is set.
- Shadow read: returns the packed shadow word (not the live word).
- CTRL write:
  - bit0 COMMIT: start a commit.
  - bit1 DISCARD: copy live → shadow and clear `dirty_o`, in one cycle.
  - Both bits set: `err_o`=1, no effect.
  - Neither bit set: no effect, `err_o`=0.
- CTRL read: bit0 = `busy_o`, bit1 = `dirty_o`, all other bits 0.
- Address > CTRL: `err_o`=1, `rdata_o`=0, no state change.
- FSM states: IDLE, APPLY, SETTLE.
  - IDLE → APPLY on a granted COMMIT write.
  - APPLY: live ← shadow (all fields in the same edge), `dirty_o` cleared; → SETTLE.
  - SETTLE: one cycle covering the crossbar's output register; → IDLE.
- `busy_o` = 1 in APPLY and SETTLE.
- `gnt_o = req_i & (state == IDLE)`. Requests are stalled (not dropped) while busy; the requester holds `req_i`/`addr_i`/`we_i`/`wdata_i` until granted.

## Timing
- Reset (async assert, deassert synchronous to `clk_i`):
  - state IDLE.
  - `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0, `dirty_o`=0.
  - `cfg_o`/shadow at identity.
- Grant at edge t → `rvalid_o`/`rdata_o`/`err_o` valid for exactly cycle t+1.
  - Back-to-back grants give back-to-back responses.
  - A shadow write granted at t is visible to a read granted at t+1.
- COMMIT granted at edge t:
  - Edge t: enter APPLY; `busy_o`=1 in cycle t+1.
  - Edge t+1: `cfg_o` takes the new values; enter SETTLE.
  - Edge t+2: enter IDLE; `busy_o`=0 in cycle t+3, where `gnt_o` may again assert.
- `cfg_o` changes only on the APPLY edge or on reset; never in IDLE or SETTLE.
- Reset mid-APPLY/SETTLE: the FSM returns to IDLE and all fields revert to identity. No partial update is visible.

## Test plan
- Reset check: assert `rst_i` → every `cfg_o[i]`=`i mod 32`, all outputs 0. Read CTRL → `rdata_o`=0, `err_o`=0.
- Write and commit: write word0=0x3FFFFFFF (six fields = 31), then CTRL=0x1.
  - `cfg_o[0..5]` stay 0..5 until the APPLY edge, then become 31.
  - `busy_o` high for exactly 2 cycles; `dirty_o` goes 1 then 0.
  - `cfg_o[6..23]` unchanged.
- Stall: hold a read request during a commit → `gnt_o`=0 through SETTLE, granted in the first IDLE cycle, response the following cycle.
- Range check with N_IN=20 (B=5): write word1 with field k=2 = 25 → `err_o`=1 and readback of word1 is unchanged. Write fields all 19 → accepted.
- Discard and bad address:
  - Write word2, then CTRL=0x2 → word2 reads back its live value, `dirty_o`=0.
  - CTRL=0x3 → `err_o`=1.
  - addr=CTRL+1 (when representable) → `err_o`=1, `rdata_o`=0.
- Reset mid-commit: assert `rst_i` in the SETTLE cycle after a commit of word0=0 → `cfg_o` back to identity, `busy_o`=0 immediately (asynchronously).

Source files
------------

// File: rtl/crossbar_cfg_if.sv
// crossbar_cfg_if: register-bus bundle for the PMU crossbar configuration block.
//
// Signals:
//   req_i    requester -> block  access request, held until granted
//   we_i     requester -> block  1 = write, 0 = read
//   addr_i   requester -> block  word index
//   wdata_i  requester -> block  write data
//   gnt_o    block -> requester  request accepted this cycle
//   rvalid_o block -> requester  response valid, one cycle after grant
//   rdata_o  block -> requester  read data, zero unless a read response
//   err_o    block -> requester  access error, valid with rvalid_o
//
// The _i/_o suffixes are relative to the configuration block (the slave).
interface crossbar_cfg_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/crossbar_cfg.sv
// crossbar_cfg: configuration front-end for the PMU event crossbar.
//
// Register-bus writes land in a shadow copy of the per-counter select
// fields (F fields of B bits packed per word). A COMMIT write on the control
// word copies the whole shadow into the live cfg_o vector in a single edge,
// bracketed by a two-cycle busy window (APPLY, SETTLE) during which new bus
// requests are stalled. A DISCARD write reloads the shadow from the live copy.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_i    asynchronous active-high reset
//   bus      register-bus slave (request/grant/response)
//   cfg_o    live select field per crossbar output
//   busy_o   commit in progress, live mapping unstable
//   dirty_o  shadow holds accepted writes not yet committed or discarded
module crossbar_cfg #(
  parameter  int N_OUT   = 24,
  parameter  int N_IN    = 32,
  parameter  int DATA_W  = 32,
  localparam int B       = $clog2(N_IN),
  localparam int F       = DATA_W / B,
  localparam int N_WORDS = (N_OUT + F - 1) / F,
  localparam int ADDR_W  = $clog2(N_WORDS + 1),
  localparam int CTRL    = N_WORDS
) (
  input  logic          clk_i,
  input  logic          rst_i,
  crossbar_cfg_if.slave bus,
  output logic [B-1:0]  cfg_o [0:N_OUT-1],
  output logic          busy_o,
  output logic          dirty_o
);

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;

  state_t            state;
  logic [B-1:0]      shadow [0:N_OUT-1];
  logic [DATA_W-1:0] shadow_word;
  logic              fields_ok;
  logic              in_words;
  logic              is_ctrl;
  logic              unused_wdata;

  // Only the low F*B data bits carry fields; the rest are deliberately ignored.
  assign unused_wdata = ^bus.wdata_i;

  assign bus.gnt_o = bus.req_i & (state == IDLE);
  assign in_words  = bus.addr_i < ADDR_W'(N_WORDS);
  assign is_ctrl   = bus.addr_i == ADDR_W'(CTRL);

  // Packed view of the addressed shadow word, and a range check of the
  // incoming write fields. Counters beyond N_OUT never match an address, so
  // their slots read as zero and their write values are not checked.
  always_comb begin
    shadow_word = '0;
    fields_ok   = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      if (bus.addr_i == ADDR_W'(i / F)) begin
        shadow_word[(i % F) * B +: B] = shadow[i];
        if (32'(bus.wdata_i[(i % F) * B +: B]) >= 32'(N_IN)) fields_ok = 1'b0;
      end
    end
  end

  // Bus responses, shadow/live storage and the commit FSM. Requests are only
  // granted in IDLE, so bus accesses and the live update never overlap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      dirty_o      <= 1'b0;
      bus.rvalid_o <= 1'b0;
      bus.rdata_o  <= '0;
      bus.err_o    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        shadow[i] <= B'(i % N_IN);
        cfg_o[i]  <= B'(i % N_IN);
      end
    end else begin
      bus.rvalid_o <= bus.gnt_o;
      bus.rdata_o  <= '0;
      bus.err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.gnt_o) begin
            if (in_words) begin
              if (!bus.we_i) begin
                bus.rdata_o <= shadow_word;
              end else if (!fields_ok) begin
                bus.err_o <= 1'b1;
              end else begin
                for (int i = 0; i < N_OUT; i++) begin
                  if (bus.addr_i == ADDR_W'(i / F)) shadow[i] <= bus.wdata_i[(i % F) * B +: B];
                end
                dirty_o <= 1'b1;
              end
            end else if (is_ctrl) begin
              if (!bus.we_i) begin
                bus.rdata_o <= DATA_W'({dirty_o, busy_o});
              end else begin
                case (bus.wdata_i[1:0])
                  2'b01: begin
                    state  <= APPLY;
                    busy_o <= 1'b1;
                  end
                  2'b10: begin
                    for (int i = 0; i < N_OUT; i++) shadow[i] <= cfg_o[i];
                    dirty_o <= 1'b0;
                  end
                  2'b11:   bus.err_o <= 1'b1;
                  default: ;
                endcase
              end
            end else begin
              bus.err_o <= 1'b1;
            end
          end
        end
        APPLY: begin
          for (int i = 0; i < N_OUT; i++) cfg_o[i] <= shadow[i];
          dirty_o <= 1'b0;
          state   <= SETTLE;
        end
        SETTLE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_cfg.sv
// tb_crossbar_cfg: self-checking bench for crossbar_cfg.
//
// Two instances share one bus stimulus: one with 32 event inputs (every
// 5-bit field legal) and one with 20 inputs (fields 20..31 rejected). A
// behavioural model per instance keeps shadow/live arrays and a busy
// countdown, and every cycle is compared against it.
module tb_crossbar_cfg;

  localparam int N_OUT   = 24;
  localparam int DATA_W  = 32;
  localparam int B       = 5;
  localparam int F       = 6;
  localparam int N_WORDS = 4;
  localparam int ADDR_W  = 3;
  localparam logic [ADDR_W-1:0] A_CTRL = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              req   = 1'b0;
  logic              we    = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [DATA_W-1:0] wdata = '0;

  crossbar_cfg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  crossbar_cfg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  assign bus_a.req_i   = req;
  assign bus_a.we_i    = we;
  assign bus_a.addr_i  = addr;
  assign bus_a.wdata_i = wdata;
  assign bus_b.req_i   = req;
  assign bus_b.we_i    = we;
  assign bus_b.addr_i  = addr;
  assign bus_b.wdata_i = wdata;

  logic [B-1:0] cfg_a [0:N_OUT-1];
  logic [B-1:0] cfg_b [0:N_OUT-1];
  logic         busy_a, dirty_a, busy_b, dirty_b;

  crossbar_cfg #(.N_OUT(N_OUT), .N_IN(32), .DATA_W(DATA_W)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a),
    .cfg_o(cfg_a), .busy_o(busy_a), .dirty_o(dirty_a)
  );

  crossbar_cfg #(.N_OUT(N_OUT), .N_IN(20), .DATA_W(DATA_W)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b),
    .cfg_o(cfg_b), .busy_o(busy_b), .dirty_o(dirty_b)
  );

  // Per-instance views of the outputs so both DUTs can be checked in a loop.
  logic              gntO    [2];
  logic              rvalidO [2];
  logic [DATA_W-1:0] rdataO  [2];
  logic              errO    [2];
  logic              busyO   [2];
  logic              dirtyO  [2];
  logic [N_OUT*B-1:0] flatO  [2];

  assign gntO[0]    = bus_a.gnt_o;
  assign gntO[1]    = bus_b.gnt_o;
  assign rvalidO[0] = bus_a.rvalid_o;
  assign rvalidO[1] = bus_b.rvalid_o;
  assign rdataO[0]  = bus_a.rdata_o;
  assign rdataO[1]  = bus_b.rdata_o;
  assign errO[0]    = bus_a.err_o;
  assign errO[1]    = bus_b.err_o;
  assign busyO[0]   = busy_a;
  assign busyO[1]   = busy_b;
  assign dirtyO[0]  = dirty_a;
  assign dirtyO[1]  = dirty_b;

  always_comb begin
    flatO[0] = '0;
    flatO[1] = '0;
    for (int i = 0; i < N_OUT; i++) begin
      flatO[0][i*B +: B] = cfg_a[i];
      flatO[1][i*B +: B] = cfg_b[i];
    end
  end

  // Behavioural model: plain integer arrays and a countdown of busy cycles.
  int nIn [2] = '{32, 20};
  int shadowM [2][N_OUT];
  int liveM   [2][N_OUT];
  bit dirtyM  [2];
  int busyLeft [2];

  int total = 0;
  int bad   = 0;

  logic              hr = 1'b0;
  logic              hw = 1'b0;
  logic [ADDR_W-1:0] ha = '0;
  logic [DATA_W-1:0] hd = '0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] wd);
    req   = r;
    we    = w;
    addr  = a;
    wdata = wd;
  endtask

  function automatic logic [127:0] modelCfg(input int d);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) v[i*B +: B] = B'(liveM[d][i]);
    return v;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N_OUT; i++) begin
        shadowM[d][i] = i % nIn[d];
        liveM[d][i]   = i % nIn[d];
      end
      dirtyM[d]   = 1'b0;
      busyLeft[d] = 0;
    end
  endtask

  // One granted access against the model, straight from the register map.
  task automatic modelAccess(input int d, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, output logic err,
                             output logic [DATA_W-1:0] rd);
    int idx;
    int fv;
    err = 1'b0;
    rd  = '0;
    if (int'(a) < N_WORDS) begin
      if (!w) begin
        for (int k = 0; k < F; k++) begin
          idx = int'(a) * F + k;
          if (idx < N_OUT) rd = rd | (DATA_W'(shadowM[d][idx]) << (k * B));
        end
      end else begin
        for (int k = 0; k < F; k++) begin
          idx = int'(a) * F + k;
          fv  = int'((wd >> (k * B)) % 32);
          if (idx < N_OUT && fv >= nIn[d]) err = 1'b1;
        end
        if (!err) begin
          for (int k = 0; k < F; k++) begin
            idx = int'(a) * F + k;
            if (idx < N_OUT) shadowM[d][idx] = int'((wd >> (k * B)) % 32);
          end
          dirtyM[d] = 1'b1;
        end
      end
    end else if (int'(a) == N_WORDS) begin
      if (!w) rd = DATA_W'(dirtyM[d]) << 1;
      else if (wd % 4 == 1) busyLeft[d] = 2;
      else if (wd % 4 == 2) begin
        for (int i = 0; i < N_OUT; i++) shadowM[d][i] = liveM[d][i];
        dirtyM[d] = 1'b0;
      end else if (wd % 4 == 3) err = 1'b1;
    end else begin
      err = 1'b1;
    end
  endtask

  // Drive one bus cycle at the falling edge, check the grant, advance the
  // model across the rising edge and check everything just after it.
  task automatic runCycle(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
    logic              expGnt [2];
    logic              expErr [2];
    logic [DATA_W-1:0] expRd  [2];
    applyStimulus(r, w, a, wd);
    #1;
    for (int d = 0; d < 2; d++) begin
      expGnt[d] = r && (busyLeft[d] == 0);
      expErr[d] = 1'b0;
      expRd[d]  = '0;
      checkOutput($sformatf("gnt%0d", d), 128'(gntO[d]), 128'(expGnt[d]));
      if (busyLeft[d] > 0) begin
        if (busyLeft[d] == 2) begin
          for (int i = 0; i < N_OUT; i++) liveM[d][i] = shadowM[d][i];
          dirtyM[d] = 1'b0;
        end
        busyLeft[d]--;
      end else if (r) begin
        modelAccess(d, w, a, wd, expErr[d], expRd[d]);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rvalid%0d", d), 128'(rvalidO[d]), 128'(expGnt[d]));
      checkOutput($sformatf("rdata%0d", d), 128'(rdataO[d]), 128'(expRd[d]));
      checkOutput($sformatf("err%0d", d), 128'(errO[d]), 128'(expErr[d]));
      checkOutput($sformatf("busy%0d", d), 128'(busyO[d]), 128'(busyLeft[d] > 0));
      checkOutput($sformatf("dirty%0d", d), 128'(dirtyO[d]), 128'(dirtyM[d]));
      checkOutput($sformatf("cfg%0d", d), 128'(flatO[d]), modelCfg(d));
    end
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_gnt%0d", tag, d), 128'(gntO[d]), 128'(0));
      checkOutput($sformatf("%s_rvalid%0d", tag, d), 128'(rvalidO[d]), 128'(0));
      checkOutput($sformatf("%s_rdata%0d", tag, d), 128'(rdataO[d]), 128'(0));
      checkOutput($sformatf("%s_err%0d", tag, d), 128'(errO[d]), 128'(0));
      checkOutput($sformatf("%s_busy%0d", tag, d), 128'(busyO[d]), 128'(0));
      checkOutput($sformatf("%s_dirty%0d", tag, d), 128'(dirtyO[d]), 128'(0));
      checkOutput($sformatf("%s_cfg%0d", tag, d), 128'(flatO[d]), modelCfg(d));
    end
  endtask

  function automatic logic [DATA_W-1:0] smallFields();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < F; k++) v[k*B +: B] = B'($urandom_range(0, 19));
    v[31:30] = 2'($urandom_range(0, 3));
    return v;
  endfunction

  // Directed scenarios first, then a randomized stretch, then reset mid-commit.
  initial begin
    applyStimulus(1'b0, 1'b0, '0, '0);
    #1 rst = 1'b1;
    #2;
    modelReset();
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    runCycle(1'b1, 1'b0, A_CTRL, 32'h0);

    // Six fields of 31 into word0, then commit and let the busy window pass.
    runCycle(1'b1, 1'b1, 3'd0, 32'h3FFF_FFFF);
    runCycle(1'b1, 1'b0, A_CTRL, 32'h0);
    runCycle(1'b1, 1'b1, A_CTRL, 32'h1);
    for (int n = 0; n < 3; n++) runCycle(1'b0, 1'b0, '0, '0);

    // Read held across a commit is stalled until IDLE.
    runCycle(1'b1, 1'b1, 3'd3, smallFields());
    runCycle(1'b1, 1'b1, A_CTRL, 32'h1);
    for (int n = 0; n < 3; n++) runCycle(1'b1, 1'b0, 3'd3, '0);
    runCycle(1'b0, 1'b0, '0, '0);

    // Field k=2 of word1 = 25: legal for 32 inputs, rejected for 20.
    runCycle(1'b1, 1'b1, 3'd1, 32'(25) << 10);
    runCycle(1'b1, 1'b0, 3'd1, '0);
    runCycle(1'b1, 1'b1, 3'd1, 32'h2739_CE73);
    runCycle(1'b1, 1'b0, 3'd1, '0);

    // Discard, double-bit control write, no-op control write, bad addresses.
    runCycle(1'b1, 1'b1, 3'd2, 32'h0123_4567 & 32'h3DEF_7BDE);
    runCycle(1'b1, 1'b1, A_CTRL, 32'h2);
    runCycle(1'b1, 1'b0, 3'd2, '0);
    runCycle(1'b1, 1'b0, A_CTRL, '0);
    runCycle(1'b1, 1'b1, A_CTRL, 32'h3);
    runCycle(1'b1, 1'b1, A_CTRL, 32'hFFFF_FFF0);
    runCycle(1'b1, 1'b0, 3'd5, '0);
    runCycle(1'b1, 1'b1, 3'd7, 32'h0000_0001);

    // Randomized traffic; a stalled request is re-presented unchanged.
    for (int n = 0; n < 400; n++) begin
      if (!(hr && busyLeft[0] != 0)) begin
        hr = ($urandom_range(0, 9) < 8);
        hw = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5, 6: ha = 3'($urandom_range(0, 3));
          7, 8:                ha = A_CTRL;
          default:             ha = 3'($urandom_range(5, 7));
        endcase
        if (ha == A_CTRL)                 hd = $urandom();
        else if ($urandom_range(0, 1) == 1) hd = smallFields();
        else                              hd = $urandom();
      end
      runCycle(hr, hw, ha, hd);
    end
    runCycle(1'b0, 1'b0, '0, '0);

    // Commit an all-zero word0 and pull reset during SETTLE.
    runCycle(1'b1, 1'b1, 3'd0, 32'h0);
    runCycle(1'b1, 1'b1, A_CTRL, 32'h1);
    runCycle(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    modelReset();
    checkResetState("midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runCycle(1'b1, 1'b0, 3'd0, '0);
    runCycle(1'b1, 1'b0, A_CTRL, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
